// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: round-robin CU/PS access to a single-port CSR, with PS writes held off while the MXU is busy
module csr_access_arbiter #(
  parameter int DATA_WIDTH_CSR   = 8,
  parameter int ADDRESS_SIZE_CSR = 32,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mxu_busy,
  input  logic                        cu_req,
  input  logic                        cu_we,
  input  logic [ADDRESS_SIZE_CSR-1:0] cu_address,
  input  logic [DATA_WIDTH_CSR-1:0]   cu_din,
  output logic                        cu_gnt,
  output logic                        cu_rvalid,
  output logic [DATA_WIDTH_CSR-1:0]   cu_rdata,
  input  logic                        ps_req,
  input  logic                        ps_we,
  input  logic [ADDRESS_SIZE_CSR-1:0] ps_address,
  input  logic [DATA_WIDTH_CSR-1:0]   ps_din,
  output logic                        ps_gnt,
  output logic                        ps_rvalid,
  output logic [DATA_WIDTH_CSR-1:0]   ps_rdata,
  output logic                        csr_ce,
  output logic                        csr_we,
  output logic [ADDRESS_SIZE_CSR-1:0] csr_address,
  output logic [DATA_WIDTH_CSR-1:0]   csr_din,
  input  logic [DATA_WIDTH_CSR-1:0]   csr_dout,
  output logic [CNT_WIDTH-1:0]        ps_blocked_cnt
);
  logic                        cu_gnt_q, cu_gnt_d, ps_gnt_q, ps_gnt_d;
  logic                        last_grant_q, last_grant_d;
  logic                        csr_ce_q, csr_ce_d, csr_we_q, csr_we_d;
  logic [ADDRESS_SIZE_CSR-1:0] csr_address_q, csr_address_d;
  logic [DATA_WIDTH_CSR-1:0]   csr_din_q, csr_din_d;
  logic                        cu_rvalid_q, cu_rvalid_d, ps_rvalid_q, ps_rvalid_d;
  logic [DATA_WIDTH_CSR-1:0]   cu_rdata_q, cu_rdata_d, ps_rdata_q, ps_rdata_d;
  logic [CNT_WIDTH-1:0]        ps_blocked_cnt_q, ps_blocked_cnt_d;
  logic                        cu_elig, ps_elig, ps_stall, cu_win, ps_win;

  always_comb begin
    cu_elig          = cu_req && !cu_gnt_q;
    ps_elig          = ps_req && !ps_gnt_q && !(ps_we && mxu_busy);
    ps_stall         = ps_req && !ps_gnt_q && ps_we && mxu_busy;
    // last_grant_q = 1 means PS was served last, so CU takes the tie
    cu_win           = cu_elig && (!ps_elig || last_grant_q);
    ps_win           = ps_elig && !cu_win;
    cu_gnt_d         = cu_win;
    ps_gnt_d         = ps_win;
    last_grant_d     = cu_win ? 1'b0 : ps_win ? 1'b1 : last_grant_q;
    csr_ce_d         = cu_win || ps_win;
    csr_we_d         = cu_win ? cu_we : ps_win ? ps_we : 1'b0;
    csr_address_d    = cu_win ? cu_address : ps_win ? ps_address : csr_address_q;
    csr_din_d        = cu_win ? cu_din : ps_win ? ps_din : csr_din_q;
    // the gnt flop doubles as the owner tag of the access on the CSR this cycle
    cu_rvalid_d      = cu_gnt_q && !csr_we_q;
    ps_rvalid_d      = ps_gnt_q && !csr_we_q;
    cu_rdata_d       = cu_rvalid_q ? csr_dout : cu_rdata_q;
    ps_rdata_d       = ps_rvalid_q ? csr_dout : ps_rdata_q;
    ps_blocked_cnt_d = (ps_stall && !(&ps_blocked_cnt_q)) ? ps_blocked_cnt_q + CNT_WIDTH'(1)
                                                           : ps_blocked_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cu_gnt_q         <= 1'b0;
      ps_gnt_q         <= 1'b0;
      last_grant_q     <= 1'b1;
      csr_ce_q         <= 1'b0;
      csr_we_q         <= 1'b0;
      csr_address_q    <= '0;
      csr_din_q        <= '0;
      cu_rvalid_q      <= 1'b0;
      ps_rvalid_q      <= 1'b0;
      cu_rdata_q       <= '0;
      ps_rdata_q       <= '0;
      ps_blocked_cnt_q <= '0;
    end else begin
      cu_gnt_q         <= cu_gnt_d;
      ps_gnt_q         <= ps_gnt_d;
      last_grant_q     <= last_grant_d;
      csr_ce_q         <= csr_ce_d;
      csr_we_q         <= csr_we_d;
      csr_address_q    <= csr_address_d;
      csr_din_q        <= csr_din_d;
      cu_rvalid_q      <= cu_rvalid_d;
      ps_rvalid_q      <= ps_rvalid_d;
      cu_rdata_q       <= cu_rdata_d;
      ps_rdata_q       <= ps_rdata_d;
      ps_blocked_cnt_q <= ps_blocked_cnt_d;
    end
  end

  // read data is presented straight from the CSR in the rvalid cycle, then held
  assign cu_gnt         = cu_gnt_q;
  assign ps_gnt         = ps_gnt_q;
  assign csr_ce         = csr_ce_q;
  assign csr_we         = csr_we_q;
  assign csr_address    = csr_address_q;
  assign csr_din        = csr_din_q;
  assign cu_rvalid      = cu_rvalid_q;
  assign ps_rvalid      = ps_rvalid_q;
  assign cu_rdata       = cu_rvalid_q ? csr_dout : cu_rdata_q;
  assign ps_rdata       = ps_rvalid_q ? csr_dout : ps_rdata_q;
  assign ps_blocked_cnt = ps_blocked_cnt_q;
endmodule
